// File: rtl/uart_pkg.sv
// Shared types and constants for the word-oriented UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int FRAME_BITS     = 10;
    localparam int BYTES_PER_WORD = 2;
    localparam int WORD_BITS      = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/uart_word_tx_if.sv
// Core-side word channel: word plus valid level toward the transmitter, done pulse back.
interface uart_word_tx_if;
    import uart_pkg::*;

    logic [WORD_BITS-1:0] data_in;
    logic                 data_in_valid;
    logic                 tx_done;

    modport master (output data_in, output data_in_valid, input tx_done);
    modport slave  (input data_in, input data_in_valid, output tx_done);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a wrap bit on each pointer; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_word_tx.sv
// Buffers 16-bit words from the core and sends each as two 8N1 frames, low byte first,
// pulsing tx_done in the last cycle of the high byte's stop bit.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rstb,
    uart_word_tx_if.slave  core,
    output logic           tx_serial,
    output logic           tx_busy,
    output logic           fifo_full,
    output logic           overflow
);
    localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = 1;

    tx_state_t            state;
    logic [BW-1:0]        baud_cnt;
    logic [2:0]           bit_cnt;
    logic                 byte_sel;
    logic [WORD_BITS-1:0] shreg;
    logic                 valid_prev;
    logic                 done_q;

    logic                 push;
    logic                 fifo_pop;
    logic                 fifo_empty;
    logic [WORD_BITS-1:0] fifo_rdata;
    logic                 baud_last;

    assign push      = core.data_in_valid && !valid_prev;
    assign baud_last = (baud_cnt == BAUD_LAST);
    // Pop on leaving IDLE, or at the end of a word's last stop bit when more words wait.
    assign fifo_pop  = !fifo_empty &&
                       ((state == IDLE) || (state == STOP && baud_last && byte_sel));
    assign tx_busy   = !fifo_empty || (state != IDLE);
    assign core.tx_done = done_q;

    sync_fifo #(.WIDTH(WORD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rstb  (rstb),
        .push  (push),
        .pop   (fifo_pop),
        .wdata (core.data_in),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            byte_sel   <= 1'b0;
            shreg      <= '0;
            tx_serial  <= 1'b1;
            done_q     <= 1'b0;
            valid_prev <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            valid_prev <= core.data_in_valid;
            done_q     <= 1'b0;
            if (push && fifo_full && !fifo_pop) overflow <= 1'b1;

            case (state)
                IDLE: begin
                    tx_serial <= 1'b1;
                    if (!fifo_empty) begin
                        shreg    <= fifo_rdata;
                        byte_sel <= 1'b0;
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    tx_serial <= 1'b0;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                DATA: begin
                    tx_serial <= shreg[0];
                    if (baud_last) begin
                        baud_cnt <= '0;
                        shreg    <= shreg >> 1;
                        if (bit_cnt == 3'd7) state <= STOP;
                        else                 bit_cnt <= bit_cnt + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                STOP: begin
                    tx_serial <= 1'b1;
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (!byte_sel) begin
                            // High byte is already in shreg[7:0] after eight shifts.
                            byte_sel <= 1'b1;
                            state    <= START;
                        end else begin
                            done_q <= 1'b1;
                            if (!fifo_empty) begin
                                shreg    <= fifo_rdata;
                                byte_sel <= 1'b0;
                                state    <= START;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Directed bench for uart_word_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4; a line
// decoder and a tx_done recorder run alongside the scenario tasks.
module tb_uart_word_tx;
    import uart_pkg::*;

    localparam int CPB = 4;
    localparam int FD  = 4;
    localparam int WORD_CYCLES = FRAME_BITS * BYTES_PER_WORD * CPB;

    logic clk  = 1'b0;
    logic rstb = 1'b0;
    logic tx_serial, tx_busy, fifo_full, overflow;

    uart_word_tx_if core_if ();

    uart_word_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .core      (core_if),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] data;
        logic       frame_ok;
        int         start;
    } rx_byte_t;

    rx_byte_t rx_q[$];
    int       done_q[$];

    // Line decoder: samples each bit in its middle cycle, 8N1.
    bit         mon_active = 1'b0;
    int         mon_pos    = 0;
    logic [9:0] mon_bits;
    rx_byte_t   mon_rb;

    initial begin
        forever begin
            @(negedge clk);
            if (!rstb) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (tx_serial === 1'b0) begin
                    mon_active   = 1'b1;
                    mon_pos      = 0;
                    mon_rb.start = cyc;
                end
            end else begin
                mon_pos++;
            end
            if (mon_active && (mon_pos % CPB) == CPB / 2) begin
                mon_bits[mon_pos / CPB] = tx_serial;
                if (mon_pos / CPB == FRAME_BITS - 1) begin
                    mon_rb.data     = mon_bits[8:1];
                    mon_rb.frame_ok = (mon_bits[0] === 1'b0) && (mon_bits[9] === 1'b1);
                    rx_q.push_back(mon_rb);
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rstb && core_if.tx_done === 1'b1) done_q.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] rx_word(input int i);
        if (rx_q.size() >= 2 * i + 2) return {rx_q[2 * i + 1].data, rx_q[2 * i].data};
        return 16'hxxxx;
    endfunction

    function automatic bit frames_ok();
        foreach (rx_q[i]) if (rx_q[i].frame_ok !== 1'b1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rx_q.delete();
        done_q.delete();
    endtask

    task automatic send_pulse(input logic [15:0] w);
        core_if.data_in       = w;
        core_if.data_in_valid = 1'b1;
        tick();
        core_if.data_in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int n = 0;
        while (tx_busy !== 1'b0 && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: tx_busy=%b after %0d cycles, expected 0", name, tx_busy, n);
        end
        repeat (2) tick();
    endtask

    task automatic test_reset();
        core_if.data_in       = '0;
        core_if.data_in_valid = 1'b0;
        rstb = 1'b0;
        repeat (3) tick();
        checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL reset_tx_serial: got %b expected 1", tx_serial); end
        checks++; if (core_if.tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done: got %b expected 0", core_if.tx_done); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_fifo_full: got %b expected 0", fifo_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        rstb = 1'b1;
        repeat (3) tick();
        checks++; if (tx_serial !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: tx_serial=%b tx_busy=%b expected 1/0", tx_serial, tx_busy); end
    endtask

    task automatic test_single_word();
        logic [19:0]    exp_line;
        logic [CPB-1:0] got;
        int             done_at;
        int             done_cnt;
        // Bits in line order: start, 0x5A LSB first, stop, start, 0xA5 LSB first, stop.
        exp_line = {1'b1, 8'hA5, 1'b0, 1'b1, 8'h5A, 1'b0};
        send_pulse(16'hA55A);
        tick();
        checks++; if (tx_serial !== 1'b1 || tx_busy !== 1'b1) begin errors++; $display("FAIL single_latency: before start bit tx_serial=%b tx_busy=%b expected 1/1", tx_serial, tx_busy); end
        done_at  = -1;
        done_cnt = 0;
        for (int b = 0; b < 20; b++) begin
            for (int c = 0; c < CPB; c++) begin
                tick();
                got[c] = tx_serial;
                if (core_if.tx_done === 1'b1) begin
                    done_cnt++;
                    done_at = b * CPB + c;
                end
            end
            checks++;
            if (got !== {CPB{exp_line[b]}}) begin
                errors++;
                $display("FAIL single_line_bit%0d: got %b expected %b", b, got, {CPB{exp_line[b]}});
            end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_at != WORD_CYCLES - 1) begin errors++; $display("FAIL single_done_cycle: got %0d expected %0d", done_at, WORD_CYCLES - 1); end
        tick();
        checks++; if (tx_serial !== 1'b1 || core_if.tx_done !== 1'b0) begin errors++; $display("FAIL single_after: tx_serial=%b tx_done=%b expected 1/0", tx_serial, core_if.tx_done); end
    endtask

    task automatic test_idle();
        bit found     = 1'b0;
        bit prev_busy = 1'b0;
        bit busy_at_done = 1'b1;
        bit busy_before  = 1'b0;
        int line_low = 0;
        int busy_hi  = 0;
        send_pulse(16'h00FF);
        for (int i = 0; i < 200 && !found; i++) begin
            prev_busy = tx_busy;
            tick();
            if (core_if.tx_done === 1'b1) begin
                found        = 1'b1;
                busy_at_done = tx_busy;
                busy_before  = prev_busy;
            end
        end
        checks++; if (!found) begin errors++; $display("FAIL idle_done_timeout: no tx_done within 200 cycles, expected one"); end
        checks++; if (busy_at_done !== 1'b0 || busy_before !== 1'b1) begin errors++; $display("FAIL idle_busy_fall: busy before/at done %b/%b expected 1/0", busy_before, busy_at_done); end
        for (int i = 0; i < 120; i++) begin
            tick();
            if (tx_serial !== 1'b1) line_low++;
            if (tx_busy !== 1'b0) busy_hi++;
        end
        checks++; if (line_low != 0 || busy_hi != 0) begin errors++; $display("FAIL idle_quiet: line-low cycles %0d busy cycles %0d expected 0/0", line_low, busy_hi); end
    endtask

    task automatic test_held_valid();
        clear_logs();
        core_if.data_in       = 16'h1234;
        core_if.data_in_valid = 1'b1;
        repeat (50) tick();
        core_if.data_in_valid = 1'b0;
        wait_idle(300, "held");
        checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL held_byte_count: got %0d expected 2", rx_q.size()); end
        checks++; if (rx_word(0) !== 16'h1234) begin errors++; $display("FAIL held_word: got %h expected 1234", rx_word(0)); end
        checks++; if (done_q.size() != 1) begin errors++; $display("FAIL held_done_count: got %0d expected 1", done_q.size()); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL held_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_overflow();
        int bad_gaps = 0;
        clear_logs();
        for (int i = 1; i <= 6; i++) begin
            send_pulse(16'(i));
            tick();
        end
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_fifo_full: got %b expected 1", fifo_full); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        wait_idle(600, "ovf");
        checks++; if (rx_q.size() != 10) begin errors++; $display("FAIL ovf_byte_count: got %0d expected 10", rx_q.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_word(i) !== 16'(i + 1)) begin
                errors++;
                $display("FAIL ovf_word%0d: got %h expected %h", i, rx_word(i), 16'(i + 1));
            end
        end
        checks++; if (!frames_ok()) begin errors++; $display("FAIL ovf_framing: bad start/stop bit seen, expected none"); end
        checks++; if (done_q.size() != 5) begin errors++; $display("FAIL ovf_done_count: got %0d expected 5", done_q.size()); end
        for (int i = 1; i < done_q.size(); i++) if (done_q[i] - done_q[i - 1] != WORD_CYCLES) bad_gaps++;
        checks++; if (bad_gaps != 0) begin errors++; $display("FAIL ovf_done_spacing: %0d gaps differ from %0d cycles", bad_gaps, WORD_CYCLES); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_push_on_pop();
        logic [15:0] exp_words [6];
        rstb = 1'b0;
        repeat (2) tick();
        rstb = 1'b1;
        tick();
        clear_logs();
        // Five words fill one serializer slot plus the FIFO; the sixth edge lands on the first pop.
        for (int t = 0; t < 82; t++) begin
            if (t == 80) begin
                checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL pop_full_before: got %b expected 1", fifo_full); end
            end
            core_if.data_in       = 16'hB000 + 16'(t);
            core_if.data_in_valid = (t == 0 || t == 2 || t == 4 || t == 6 || t == 8 || t == 81);
            tick();
        end
        core_if.data_in_valid = 1'b0;
        checks++; if (core_if.tx_done !== 1'b1) begin errors++; $display("FAIL pop_coincide_done: tx_done=%b expected 1", core_if.tx_done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pop_overflow: got %b expected 0", overflow); end
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL pop_full_after: got %b expected 1", fifo_full); end
        wait_idle(600, "pop");
        exp_words = '{16'hB000, 16'hB002, 16'hB004, 16'hB006, 16'hB008, 16'hB051};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (rx_word(i) !== exp_words[i]) begin
                errors++;
                $display("FAIL pop_word%0d: got %h expected %h", i, rx_word(i), exp_words[i]);
            end
        end
        checks++; if (done_q.size() != 6) begin errors++; $display("FAIL pop_done_count: got %0d expected 6", done_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        clear_logs();
        send_pulse(16'hC33C);
        repeat (59) tick();
        // Now inside bit 3 of the high byte 0xC3, which is 0 on the line.
        checks++; if (tx_serial !== 1'b0) begin errors++; $display("FAIL mid_line_low: got %b expected 0", tx_serial); end
        rstb = 1'b0;
        #1;
        checks++; if (tx_serial !== 1'b1) begin errors++; $display("FAIL mid_async_line: got %b expected 1", tx_serial); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL mid_busy_in_reset: got %b expected 0", tx_busy); end
        repeat (2) tick();
        rstb = 1'b1;
        tick();
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL mid_busy_release: got %b expected 0", tx_busy); end
        repeat (100) tick();
        checks++; if (done_q.size() != 0) begin errors++; $display("FAIL mid_no_done: got %0d pulses expected 0", done_q.size()); end
        clear_logs();
        send_pulse(16'h5AA5);
        wait_idle(300, "mid");
        checks++; if (rx_word(0) !== 16'h5AA5 || rx_q.size() != 2) begin errors++; $display("FAIL mid_next_word: got %h (%0d bytes) expected 5aa5 (2 bytes)", rx_word(0), rx_q.size()); end
        checks++; if (done_q.size() != 1 || !frames_ok()) begin errors++; $display("FAIL mid_next_done: done pulses %0d framing ok %b expected 1/1", done_q.size(), frames_ok()); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_idle();
        test_held_valid();
        test_overflow();
        test_push_on_pop();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Serial transmit stage downstream of the processing core: accepts 16-bit result words on the core's `data_out` / `data_out_valid` channel and shifts each word out as two 8N1 UART frames, low byte first. Words are buffered in a small FIFO so the core is never stalled mid-burst. The block returns a one-cycle `tx_done` pulse to the core after every completed word.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥2.
- `FIFO_DEPTH`, 4: word buffer entries; power of two, ≥2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rstb`  in  1  reset, asynchronous, active-low.
- `data_in`  in  16  word from the core (`data_out`).
- `data_in_valid`  in  1  level from the core (`data_out_valid`); a rising edge marks a new word.
- `tx_serial`  out  1  UART line, idle high.
- `tx_done`  out  1  one-cycle pulse at the end of each word's second stop bit.
- `tx_busy`  out  1  high while the FIFO is non-empty or the serializer is not IDLE.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` words.
- `overflow`  out  1  sticky; set when a word is dropped; cleared only by reset.

## Operation
- Reset values: `tx_serial`=1, `tx_done`=0, `tx_busy`=0, `fifo_full`=0, `overflow`=0; FIFO empty; FSM in IDLE; `valid_prev`=0.
- Edge detect: `push` = `data_in_valid` & !`valid_prev`, with `valid_prev` registered every cycle. A held-high level pushes only one word.
- Push while full and no pop in the same cycle: the word is dropped and `overflow` is set. Push and pop in the same cycle while full: both take effect and the word is kept.
- FSM states: IDLE, START, DATA, STOP. A `bit_cnt` (0–7) counts bits, `byte_sel` (0/1) selects the byte, and `baud_cnt` runs from 0 to `CLKS_PER_BIT`-1.
- IDLE → START when the FIFO is non-empty. On that transition the FSM pops the FIFO, loads the 16-bit shift register, and clears `byte_sel`.
- START: drives 0 for one bit time, then → DATA.
- DATA: drives shreg[0], LSB first, for 8 bit times, shifting right after each; then → STOP.
- STOP: drives 1 for one bit time, then:
  - if `byte_sel`=0: set `byte_sel`=1 and → START; the high byte follows with no idle gap.
  - if `byte_sel`=1: pulse `tx_done`, then → START with a pop if the FIFO is non-empty, else → IDLE.
- `tx_serial` is registered, and equals 1 in IDLE.

## Timing
- Latency: with the rising edge of `data_in_valid` sampled at edge k into an empty FIFO and IDLE FSM:
  - write at edge k.
  - `tx_serial` falls at edge k+2 (FIFO write, then FSM pop/load, then registered output).
- Word duration is 20×`CLKS_PER_BIT` cycles. `tx_done` is high for exactly 1 cycle, in the final cycle of the high byte's stop bit.
- Back-to-back words: the next start bit immediately follows the stop bit, with no extra cycles.
- `fifo_full` and `tx_busy` are combinational from registered state, with no added latency.
- Reset mid-frame: `tx_serial` goes to 1 asynchronously, the FIFO is flushed, and no `tx_done` is issued for the aborted word.
- `data_in` must be stable in the cycle the rising edge is sampled; it is captured only at that edge.

## Structure
- Package `uart_pkg` holds:
  - `tx_state_t` enum {IDLE, START, DATA, STOP}.
  - `FRAME_BITS`=10.
  - `BYTES_PER_WORD`=2.
- Sub-module `sync_fifo`, parameterized by width and depth:
  - ports `push`, `pop`, `wdata`, `rdata`, `full`, `empty`.
  - supports simultaneous push/pop when full.
- The top module contains the edge detector, overflow flag, baud counter and FSM.

## Test plan
Benches run with `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Single word 0xA55A:
  - line carries 0, then 0,1,0,1,1,0,1,0, then 1 (low byte 0x5A).
  - then 0, then 1,0,1,0,0,1,0,1, then 1 (high byte 0xA5).
  - each bit lasts 4 cycles; `tx_done` pulses once, 80 cycles after the start bit begins.
- `data_in_valid` held high for 50 cycles with 0x1234 → exactly one word sent; `tx_done` count is 1.
- Six rising edges spaced 2 cycles apart (0x0001..0x0006):
  - words 1–5 are sent contiguously: one in flight plus 4 in the FIFO.
  - word 6 is dropped; `overflow`=1 and stays 1.
  - `tx_done` pulses 5 times at 80-cycle intervals.
- Push coinciding with the pop cycle while `fifo_full`=1 → the word is accepted and `overflow` stays 0.
- Assert `rstb` low in the middle of the DATA state of the high byte:
  - `tx_serial`=1 immediately, and `tx_busy`=0 after release.
  - no `tx_done` pulse; the next word after release transmits correctly.
- Idle check: `tx_busy` falls in the same cycle the FSM returns to IDLE after the last `tx_done`, and `tx_serial` stays 1 for ≥100 cycles.
